crossbar_slave_mem: RTL

CROSSBAR_SLAVE_MEM -- requirements
Module: crossbar_slave_mem

---
 rtl/crossbar_slave_mem.sv | 109 ++++++++++
 1 files changed

// File: rtl/crossbar_slave_mem.sv
// Crossbar memory responder: single outstanding request, programmable wait states,
// decode error on a slave-select mismatch, and req-held-high protection via HOLD.
module crossbar_slave_mem #(
   parameter int SLAVE_ID    = 0,
   parameter int WAIT_CYCLES = 2,
   parameter int DEPTH_LOG2  = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req,
   input  logic        cmd,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        ack,
   output logic [31:0] rdata,
   output logic        err,
   output logic        busy
);

   localparam int DEPTH = 1 << DEPTH_LOG2;

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACK, ST_HOLD} state_t;

   state_t                  state, state_nxt;
   logic [3:0]              cnt;
   logic                    lat_sel;
   logic                    lat_cmd;
   logic [DEPTH_LOG2-1:0]   lat_idx;
   logic [31:0]             lat_wdata;
   logic [31:0]             mem [DEPTH];

   logic                    acc_sel;
   logic                    acc_cmd;
   logic [DEPTH_LOG2-1:0]   acc_idx;
   logic [31:0]             acc_wdata;
   logic                    acc_hit;
   logic                    enter_ack;
   logic                    unused_addr_bits;

   // Aliasing: only the select bit and the word index take part in decoding.
   assign unused_addr_bits = ^addr[30:DEPTH_LOG2];

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (req) state_nxt = (WAIT_CYCLES == 0) ? ST_ACK : ST_WAIT;
         ST_WAIT: if (cnt == 4'd1) state_nxt = ST_ACK;
         ST_ACK:  state_nxt = req ? ST_HOLD : ST_IDLE;
         ST_HOLD: if (!req) state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // With zero wait states the access happens on the sampling edge itself,
   // so the request fields come straight from the ports instead of the latch.
   always_comb begin
      acc_sel   = lat_sel;
      acc_cmd   = lat_cmd;
      acc_idx   = lat_idx;
      acc_wdata = lat_wdata;
      if (state == ST_IDLE) begin
         acc_sel   = addr[31];
         acc_cmd   = cmd;
         acc_idx   = addr[DEPTH_LOG2-1:0];
         acc_wdata = wdata;
      end
      acc_hit   = (acc_sel == SLAVE_ID[0]);
      enter_ack = (state_nxt == ST_ACK);
   end

   always_ff @(posedge clk) begin
      if (state == ST_IDLE && req) begin
         lat_sel   <= addr[31];
         lat_cmd   <= cmd;
         lat_idx   <= addr[DEPTH_LOG2-1:0];
         lat_wdata <= wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         cnt   <= 4'd0;
         ack   <= 1'b0;
         err   <= 1'b0;
         busy  <= 1'b0;
         rdata <= 32'd0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= 32'd0;
      end else begin
         state <= state_nxt;
         busy  <= (state_nxt != ST_IDLE);
         ack   <= enter_ack;
         err   <= enter_ack && !acc_hit;
         if (state == ST_IDLE && req)
            cnt <= 4'(WAIT_CYCLES);
         else if (state == ST_WAIT)
            cnt <= cnt - 4'd1;
         if (enter_ack) begin
            if (!acc_hit)
               rdata <= 32'hDEAD_BEEF;
            else if (acc_cmd)
               mem[acc_idx] <= acc_wdata;
            else
               rdata <= mem[acc_idx];
         end
      end
   end

endmodule
